// File: rtl/pipe_skid_stage.sv
// Elastic two-entry pipeline stage (main + skid register) with valid/ready on both sides.
// in_ready is decoded from registered occupancy only, so a downstream stall reaches upstream one cycle later.
module pipe_skid_stage #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [1:0]   count
);

  // Encoding equals occupancy, so count is the state itself; skid-without-main is unrepresentable.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e       state_q;
  logic [N-1:0] main_q;
  logic [N-1:0] skid_q;
  logic         in_xfer;
  logic         out_xfer;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign count     = state_q;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      // Data registers keep stale contents; only occupancy is cleared.
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_q  <= in_data;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_q <= in_data;
          end else if (in_xfer) begin
            skid_q  <= in_data;
            state_q <= FULL;
          end else if (out_xfer) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_q  <= skid_q;
            state_q <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Elastic two-entry pipeline stage with a valid/ready handshake on both sides. It is the consuming end of a load-enabled register.
- It accepts a word whenever it has room and holds it until the downstream stage takes it.
- It is placed between CPU pipeline stages (e.g. IF/ID, ID/EX), so a downstream stall propagates upstream one cycle later through a registered ready, with no combinational ready path.
- A synchronous flush discards in-flight words on branch mispredict or trap.

Parameters:
N, 32, data word width in bits

Ports:
clk        input   1  clock; all state updates on rising edge
rst_n      input   1  asynchronous active-low reset
flush      input   1  synchronous discard of all held words
in_valid   input   1  upstream presents in_data
in_ready   output  1  stage can accept a word this cycle (registered)
in_data    input   N  upstream word
out_valid  output  1  out_data holds a valid word
out_ready  input   1  downstream accepts out_data this cycle
out_data   output  N  word at head of stage (registered)
count      output  2  number of held words, 0..2

Behaviour:
- Storage:
  - main register: main_data, main_valid; drives out_data and out_valid.
  - skid register: skid_data, skid_valid.
- Handshakes:
  - Input transfer: in_valid && in_ready at a clock edge.
  - Output transfer: out_valid && out_ready at a clock edge.
- Reset (rst_n low, asynchronous): main_valid=0, skid_valid=0, main_data=0, skid_data=0, out_valid=0, out_data=0, count=0, in_ready=1. This holds for as long as rst_n is low. Reset in the middle of a transfer drops both words with no partial update.
- in_ready = !skid_valid. It is purely a function of registered state and never depends on out_ready in the same cycle.
- count = main_valid + skid_valid. States:
  - EMPTY (0 words)
  - ONE (main only)
  - FULL (main + skid)
  - skid_valid && !main_valid is illegal and must never occur.
- Transitions, with no flush:
  - EMPTY, in xfer -> ONE; main <= in_data.
  - EMPTY, no xfer -> EMPTY.
  - ONE, in xfer and out xfer -> ONE; main <= in_data (pass-through, 1 word/cycle).
  - ONE, in xfer only -> FULL; skid <= in_data; main unchanged.
  - ONE, out xfer only -> EMPTY.
  - ONE, neither -> ONE; main held.
  - FULL, out xfer -> ONE; main <= skid; skid_valid <= 0. No input is possible because in_ready=0.
  - FULL, no out xfer -> FULL; both held stable.
- Latency and throughput:
  - An accepted word appears on out_data/out_valid the cycle after acceptance, a minimum 1-cycle latency.
  - Steady-state throughput is 1 word per cycle while out_ready stays high.
- Ordering: strict FIFO. The skid word is always younger than the main word. No word is duplicated or dropped unless flush or reset occurs.
- Stability: while out_valid=1 and out_ready=0, out_data must not change.
- Flush:
  - At the edge where flush=1: main_valid <= 0, skid_valid <= 0, count <= 0.
  - A same-cycle input transfer is discarded, and so is a same-cycle output transfer of the old word (downstream sees it consumed; the stage forgets it).
  - After a flush edge, in_ready=1.
  - Data registers may keep stale contents, but out_valid=0.
- Flush has priority over every transition. Flush with reset asserted: reset wins.
- out_ready with out_valid=0 is ignored. in_data with in_valid=0 is ignored.

Test Plan:
- Reset, then stream 0x00000001..0x00000008 with in_valid=1 and out_ready=1 every cycle -> out_data follows 1 cycle behind, one word per cycle, count stays 1, in_ready stays 1.
- From ONE holding 0xAAAA0001, hold out_ready=0 and offer 0xAAAA0002 -> next cycle count=2, in_ready=0, out_data stays 0xAAAA0001. Then raise out_ready for 2 cycles -> out_data 0xAAAA0001 then 0xAAAA0002, count 2->1->0, in_ready returns to 1.
- Random in_valid/out_ready, 1000 words of incrementing data -> scoreboard output equals input order exactly; count never exceeds 2; in_ready==(count<2 or count==2 is never accepted).
- FULL state (0x11, 0x22) with flush=1 and in_valid=1 carrying 0x33 -> next cycle out_valid=0, count=0, in_ready=1; 0x33 never appears at the output.
- Drive rst_n low mid-stream with count=2, asynchronously between edges -> out_valid=0, count=0 and in_ready=1 immediately. After rst_n rises, the first accepted word 0x5A5A5A5A appears 1 cycle later.
- Hold out_ready=0 for 10 cycles with count=2 -> out_data constant and in_ready=0 throughout; no acceptance even with in_valid=1.
